// File: rtl/packet_det_sdiv_32s_16s_16_seq.sv
// Iterative restoring signed divider, one quotient bit per clock, with ap_start/ap_done handshake.
// Quotient saturates to the 16-bit range; divide-by-zero returns a signed full-scale value.
module packet_det_sdiv_32s_16s_16_seq #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 16,
    parameter int QUOT_W     = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_idle,
    output logic                  ap_ready,
    output logic                  ap_done,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic [QUOT_W-1:0]     quot,
    output logic [QUOT_W-1:0]     rem,
    output logic                  ovf,
    output logic                  dbz
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam int PR_W  = DIVISOR_W + 1;
    localparam logic [QUOT_W-1:0] Q_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] Q_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_dvd;   // dividend magnitude; quotient bits shift in at the LSB
    logic [PR_W-1:0]       r_dvs;
    logic [PR_W-1:0]       r_rem;
    logic                  r_sign_q;
    logic                  r_sign_r;
    logic                  r_dbz_p;

    logic                  w_accept;
    logic [DIVIDEND_W-1:0] w_abs0;
    logic [PR_W-1:0]       w_din1_x;
    logic [PR_W-1:0]       w_abs1;
    logic [PR_W-1:0]       w_shift;
    logic                  w_ge;
    logic [PR_W-1:0]       w_rem_nx;
    logic [DIVIDEND_W-1:0] w_qmag;
    logic [QUOT_W-1:0]     w_q_lo;
    logic [QUOT_W-1:0]     w_r_lo;
    logic [QUOT_W-1:0]     w_quot_fix;
    logic [QUOT_W-1:0]     w_rem_fix;
    logic                  w_ovf_fix;
    logic                  w_unused;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ap_start) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign ap_idle  = (r_state == S_IDLE);
    assign ap_ready = w_accept & ~ap_rst;
    assign ap_done  = (r_state == S_DONE);

    assign w_abs0   = din0[DIVIDEND_W-1] ? -din0 : din0;
    assign w_din1_x = {din1[DIVISOR_W-1], din1};
    assign w_abs1   = din1[DIVISOR_W-1] ? -w_din1_x : w_din1_x;

    assign w_shift  = {r_rem[PR_W-2:0], r_dvd[DIVIDEND_W-1]};
    assign w_ge     = (w_shift >= r_dvs);
    assign w_rem_nx = w_ge ? (w_shift - r_dvs) : w_shift;
    assign w_qmag   = {r_dvd[DIVIDEND_W-2:0], w_ge};
    assign w_q_lo   = w_qmag[QUOT_W-1:0];
    assign w_r_lo   = w_rem_nx[QUOT_W-1:0];

    // The remainder magnitude is always below the divisor magnitude, so the top bits are zero.
    assign w_unused = ^{r_rem[PR_W-1], w_rem_nx[PR_W-1:QUOT_W]};

    // Final results are formed from the last iteration so they are valid in the DONE cycle.
    always_comb begin
        w_quot_fix = r_sign_q ? -w_q_lo : w_q_lo;
        w_rem_fix  = r_sign_r ? -w_r_lo : w_r_lo;
        w_ovf_fix  = 1'b0;
        if (!r_sign_q && (w_qmag > {{(DIVIDEND_W-QUOT_W){1'b0}}, Q_MAX})) begin
            w_quot_fix = Q_MAX;
            w_ovf_fix  = 1'b1;
        end else if (r_sign_q && (w_qmag > {{(DIVIDEND_W-QUOT_W){1'b0}}, Q_MIN})) begin
            w_quot_fix = Q_MIN;
            w_ovf_fix  = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dbz_p  <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            ovf      <= 1'b0;
            dbz      <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= CNT_W'(DIVIDEND_W - 1);
            r_dvd    <= w_abs0;
            r_dvs    <= w_abs1;
            r_rem    <= '0;
            r_sign_q <= din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
            r_sign_r <= din0[DIVIDEND_W-1];
            r_dbz_p  <= (din1 == '0);
        end else if (r_state == S_CALC) begin
            r_dvd <= w_qmag;
            r_rem <= w_rem_nx;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (r_dbz_p) begin
                quot <= r_sign_r ? Q_MIN : Q_MAX;
                rem  <= '0;
                ovf  <= 1'b0;
                dbz  <= 1'b1;
            end else begin
                quot <= w_quot_fix;
                rem  <= w_rem_fix;
                ovf  <= w_ovf_fix;
                dbz  <= 1'b0;
            end
        end
    end

endmodule
